mic_volume_level: RTL
=====================

# mic_volume_level

Converts the 12-bit microphone sample stream into a 4-bit volume level and a 4-bit peak-hold level for the LED bar and display logic. It sits between the mic ADC sampler and the LED bar driver. The LED bar driver turns `volume_level` 0..15 into a thermometer pattern of 1..16 LEDs. The block finds the maximum sample over a fixed window of accepted samples, quantises it to 16 levels and publishes the result once per window. An optional peak-hold/decay level is published alongside it for the peak/volume display select switch.

## Interface
Parameters:
- `WINDOW_LEN`, default 4000: accepted samples per measurement window. Legal range is 2..65535.
- `PEAK_HOLD_WINDOWS`, default 4: number of windows a new peak is held before decay starts. Legal range is 0..15.

Ports:
- `clk` input, 1 bit: system clock; all state updates on the rising edge.
- `rst` input, 1 bit: one clock; reset is asynchronous and active-high.
- `sample_valid` input, 1 bit: `mic_in` is valid this cycle and is accepted.
- `mic_in` input, 12 bits: unsigned mic sample, 0..4095.
- `volume_level` output, 4 bits: window maximum quantised to 0..15; registered.
- `peak_level` output, 4 bits: peak-hold level, 0..15; registered.
- `level_valid` output, 1 bit: one-cycle pulse when both level outputs have just updated.

## Operation
- Internal state:
  - `win_cnt`: counts accepted samples, 0..`WINDOW_LEN`-1.
  - `run_max`: running maximum of the current window, 12 bits.
  - `hold_cnt`: windows left in the peak hold, 4 bits.
- Cycles with `sample_valid`=0 change no state; `level_valid` is 0.
- Accepted sample when `win_cnt` < `WINDOW_LEN`-1:
  - `run_max` <= max(`run_max`, `mic_in`).
  - `win_cnt` increments.
- Accepted sample when `win_cnt` = `WINDOW_LEN`-1 (window end):
  - m = max(`run_max`, `mic_in`), so the last sample counts toward this window.
  - `volume_level` <= m[11:8]. Thus 0..255 gives level 0 and 3840..4095 gives level 15.
  - `run_max` <= 0 and `win_cnt` <= 0.
  - `level_valid` <= 1 for exactly one cycle.
  - The peak is updated as below.
- Peak update, evaluated only at window end, with L = new level and P = current `peak_level`:
  - If L >= P: `peak_level` <= L and `hold_cnt` <= `PEAK_HOLD_WINDOWS`.
  - Else if `hold_cnt` != 0: `hold_cnt` decrements and P is unchanged.
  - Else: `peak_level` <= max(L, P-1), so it decays one step per window and never drops below L.
- Comparison and quantisation are unsigned; no arithmetic wrap is possible. P-1 is only taken when P > L >= 0.

## Timing
- Reset values: `volume_level`=0, `peak_level`=0, `level_valid`=0, `win_cnt`=0, `run_max`=0, `hold_cnt`=0.
- Latency: the outputs change on the same rising edge that accepts the final sample of the window. `level_valid` is high during the following cycle only.
- Consecutive `sample_valid` cycles are all accepted; the block never stalls or back-pressures.
- If `WINDOW_LEN` samples arrive back-to-back, `level_valid` pulses once every `WINDOW_LEN` accepted samples.
- Reset asserted mid-window discards the partial window. The first window after reset release starts counting from 0.
- `sample_valid` at the same edge that `rst` deasserts: the sample is ignored if `rst` is still high at that edge.

## Configuration
- `MIC_VOLUME_PEAK_HOLD_EN` defined:
  - Peak-hold/decay logic and `hold_cnt` are built.
  - `peak_level` behaves as in Operation.
- `MIC_VOLUME_PEAK_HOLD_EN` not defined:
  - No hold/decay logic is built.
  - `peak_level` is driven from the same register as `volume_level` and always equals it.
  - All other behaviour is identical.

## Test plan
Bench uses `WINDOW_LEN`=4 and `PEAK_HOLD_WINDOWS`=2 unless stated.
- Reset then idle: hold `rst` for 3 cycles with no `sample_valid` -> all outputs 0 and no `level_valid` pulse.
- Single window: samples 100, 3000, 20, 5 back-to-back -> `volume_level`=11 and `peak_level`=11 on the 4th accept edge, `level_valid` high exactly one cycle.
- Last-sample boundary: samples 0, 0, 0, 4095 -> `volume_level`=15. Gapped valids (1 cycle on, 3 off) with the same data give the same result.
- Peak hold and decay: window levels 12, 3, 3, 3, 3, 3 -> `peak_level` sequence 12, 12, 12, 11, 10, 9 while `volume_level`=3. With the macro undefined, `peak_level`=12, 3, 3, 3, 3, 3.
- Reset mid-window: accept 4000 and 4000, assert `rst`, then send 256, 256, 256, 256 -> `volume_level`=1 and no stale level 15.
- Boundary quantisation: windows with maxima 255, 256, 3839, 3840 -> levels 0, 1, 14, 15.

Source files
------------

// File: rtl/mic_volume_level.sv
// Purpose : converts a 12-bit mic sample stream into a 4-bit windowed volume level and a 4-bit peak level.
// Latency : levels update on the edge that accepts the last sample of a window; level_valid is high the following cycle.
// Backpr. : none; every sample_valid cycle is accepted and the block never stalls.
//
// Ports:
//   clk          - system clock, rising edge
//   rst          - asynchronous active-high reset
//   sample_valid - mic_in is valid and accepted this cycle
//   mic_in       - unsigned 12-bit mic sample
//   volume_level - window maximum quantised to 0..15 (registered)
//   peak_level   - peak-hold level 0..15 (registered)
//   level_valid  - one-cycle pulse when both levels have just updated
//
// Build option: define MIC_VOLUME_PEAK_HOLD_EN to build the peak hold/decay logic.
// Without it, peak_level mirrors volume_level from the same register.
module mic_volume_level #(
    parameter int WINDOW_LEN        = 4000,
    parameter int PEAK_HOLD_WINDOWS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sample_valid,
    input  logic [11:0] mic_in,
    output logic [3:0]  volume_level,
    output logic [3:0]  peak_level,
    output logic        level_valid
);

    // Out-of-range parameters would silently truncate counters; reject them at elaboration.
    generate
        if (WINDOW_LEN < 2 || WINDOW_LEN > 65535 ||
            PEAK_HOLD_WINDOWS < 0 || PEAK_HOLD_WINDOWS > 15) begin : g_bad_param
            $error("mic_volume_level: WINDOW_LEN or PEAK_HOLD_WINDOWS out of range");
        end
    endgenerate

    localparam logic [15:0] WIN_LAST = 16'(WINDOW_LEN - 1);

    logic [15:0] win_cnt_q, win_cnt_d;
    logic [11:0] run_max_q, run_max_d;
    logic [3:0]  volume_q, volume_d;
    logic        level_valid_q, level_valid_d;

    logic [11:0] max_with_in;
    logic        win_end;

    // The sample accepted on the window-end edge still counts toward that window.
    assign max_with_in = (mic_in > run_max_q) ? mic_in : run_max_q;
    assign win_end     = sample_valid && (win_cnt_q == WIN_LAST);

    always_comb begin
        win_cnt_d     = win_cnt_q;
        run_max_d     = run_max_q;
        volume_d      = volume_q;
        level_valid_d = 1'b0;
        if (sample_valid) begin
            if (win_end) begin
                volume_d      = max_with_in[11:8];
                run_max_d     = 12'd0;
                win_cnt_d     = 16'd0;
                level_valid_d = 1'b1;
            end else begin
                run_max_d = max_with_in;
                win_cnt_d = win_cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_cnt_q     <= 16'd0;
            run_max_q     <= 12'd0;
            volume_q      <= 4'd0;
            level_valid_q <= 1'b0;
        end else begin
            win_cnt_q     <= win_cnt_d;
            run_max_q     <= run_max_d;
            volume_q      <= volume_d;
            level_valid_q <= level_valid_d;
        end
    end

`ifdef MIC_VOLUME_PEAK_HOLD_EN
    localparam logic [3:0] HOLD_INIT = 4'(PEAK_HOLD_WINDOWS);

    logic [3:0] peak_q, peak_d;
    logic [3:0] hold_cnt_q, hold_cnt_d;
    logic [3:0] new_level;
    logic [3:0] peak_dec;

    assign new_level = max_with_in[11:8];
    // Only used when peak_q > new_level, so peak_q >= 1 and this cannot wrap.
    assign peak_dec  = peak_q - 4'd1;

    always_comb begin
        peak_d     = peak_q;
        hold_cnt_d = hold_cnt_q;
        if (win_end) begin
            if (new_level >= peak_q) begin
                peak_d     = new_level;
                hold_cnt_d = HOLD_INIT;
            end else if (hold_cnt_q != 4'd0) begin
                hold_cnt_d = hold_cnt_q - 4'd1;
            end else begin
                // Decay one step per window, but never below the current window level.
                peak_d = (peak_dec > new_level) ? peak_dec : new_level;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            peak_q     <= 4'd0;
            hold_cnt_q <= 4'd0;
        end else begin
            peak_q     <= peak_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

    assign peak_level = peak_q;
`else
    assign peak_level = volume_q;
`endif

    assign volume_level = volume_q;
    assign level_valid  = level_valid_q;

endmodule
